// File: rtl/id_ex_control_stage.sv
// ID-stage decoder and ID/EX pipeline register: produces alu_opcode/func and
// main controls for EX, and raises a one-cycle load-use stall request.
module id_ex_control_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_instr,
  input  logic              ex_hold,
  input  logic              ex_flush,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [3:0]        ex_alu_opcode,
  output logic [5:0]        ex_func,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_wreg,
  output logic [DATA_W-1:0] ex_imm,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_alu_src,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic              ex_jr,
  output logic              illegal_flag
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_ADDIU = 6'b001001,
    OP_ORI   = 6'b001101,
    OP_LUI   = 6'b001111,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } op_e;

  typedef enum logic [5:0] {
    FN_JR   = 6'b001000,
    FN_ADDU = 6'b100001,
    FN_SUBU = 6'b100011
  } fn_e;

  typedef enum logic [3:0] {
    ALU_RTYPE = 4'b0000,
    ALU_ADD   = 4'b0001,
    ALU_SUB   = 4'b0010,
    ALU_LUI   = 4'b0011,
    ALU_OR    = 4'b0100
  } alu_e;

  // Instruction fields
  logic [5:0]        w_op;
  logic [5:0]        w_func;
  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  logic [REG_AW-1:0] w_rd;
  logic [15:0]       w_imm16;
  logic [DATA_W-1:0] w_imm_sext;
  logic [DATA_W-1:0] w_imm_zext;
  logic              w_unused;

  assign w_op       = id_instr[31:26];
  assign w_func     = id_instr[5:0];
  assign w_rs       = id_instr[21 +: REG_AW];
  assign w_rt       = id_instr[16 +: REG_AW];
  assign w_rd       = id_instr[11 +: REG_AW];
  assign w_imm16    = id_instr[15:0];
  assign w_imm_sext = {{(DATA_W-16){w_imm16[15]}}, w_imm16};
  assign w_imm_zext = {{(DATA_W-16){1'b0}}, w_imm16};
  assign w_unused   = ^id_instr[10:6];

  // Decoded controls
  alu_e              w_alu_opcode;
  logic [REG_AW-1:0] w_wreg;
  logic [DATA_W-1:0] w_imm;
  logic              w_reg_write;
  logic              w_mem_read;
  logic              w_mem_write;
  logic              w_mem_to_reg;
  logic              w_alu_src;
  logic              w_branch;
  logic              w_jump;
  logic              w_jr;
  logic              w_use_rt;
  logic              w_illegal;

  always_comb begin
    w_alu_opcode = ALU_RTYPE;
    w_wreg       = w_rt;
    w_imm        = w_imm_sext;
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src    = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_jr         = 1'b0;
    w_use_rt     = 1'b0;
    w_illegal    = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_alu_opcode = ALU_RTYPE;
        w_wreg       = w_rd;
        w_use_rt     = 1'b1;
        case (w_func)
          FN_ADDU, FN_SUBU: w_reg_write = 1'b1;
          FN_JR:            w_jr        = 1'b1;
          default:          w_illegal   = 1'b1;
        endcase
      end
      OP_ADDIU: begin
        w_alu_opcode = ALU_ADD;
        w_alu_src    = 1'b1;
        w_reg_write  = 1'b1;
      end
      OP_ORI: begin
        w_alu_opcode = ALU_OR;
        w_alu_src    = 1'b1;
        w_reg_write  = 1'b1;
        w_imm        = w_imm_zext;
      end
      OP_LUI: begin
        w_alu_opcode = ALU_LUI;
        w_alu_src    = 1'b1;
        w_reg_write  = 1'b1;
        w_imm        = w_imm_zext;
      end
      OP_LW: begin
        w_alu_opcode = ALU_ADD;
        w_alu_src    = 1'b1;
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
      end
      OP_SW: begin
        w_alu_opcode = ALU_ADD;
        w_alu_src    = 1'b1;
        w_mem_write  = 1'b1;
        w_use_rt     = 1'b1;
      end
      OP_BEQ: begin
        w_alu_opcode = ALU_SUB;
        w_branch     = 1'b1;
        w_use_rt     = 1'b1;
      end
      OP_J: begin
        w_alu_opcode = ALU_ADD;
        w_jump       = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // ID/EX register
  logic              r_valid;
  logic [3:0]        r_alu_opcode;
  logic [5:0]        r_func;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_wreg;
  logic [DATA_W-1:0] r_imm;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_mem_to_reg;
  logic              r_alu_src;
  logic              r_branch;
  logic              r_jump;
  logic              r_jr;
  logic              r_illegal;

  // Only a load already in EX can stall; its bubble clears r_mem_read next cycle.
  logic w_stall;
  logic w_load;

  assign w_stall = id_valid & r_valid & r_mem_read & (r_wreg != '0) &
                   ((w_rs == r_wreg) | (w_use_rt & (w_rt == r_wreg)));
  assign w_load  = id_valid & ~w_illegal & ~ex_flush & ~w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_alu_opcode <= '0;
      r_func       <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_wreg       <= '0;
      r_imm        <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu_src    <= 1'b0;
      r_branch     <= 1'b0;
      r_jump       <= 1'b0;
      r_jr         <= 1'b0;
    end else if (!ex_hold) begin
      r_func       <= w_func;
      r_rs         <= w_rs;
      r_rt         <= w_rt;
      r_wreg       <= w_wreg;
      r_imm        <= w_imm;
      r_valid      <= w_load;
      r_alu_opcode <= w_load ? w_alu_opcode : ALU_RTYPE;
      r_reg_write  <= w_load & w_reg_write;
      r_mem_read   <= w_load & w_mem_read;
      r_mem_write  <= w_load & w_mem_write;
      r_mem_to_reg <= w_load & w_mem_to_reg;
      r_alu_src    <= w_load & w_alu_src;
      r_branch     <= w_load & w_branch;
      r_jump       <= w_load & w_jump;
      r_jr         <= w_load & w_jr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_illegal <= 1'b0;
    else if (id_valid && w_illegal)
      r_illegal <= 1'b1;
  end

  assign id_stall      = w_stall;
  assign ex_valid      = r_valid;
  assign ex_alu_opcode = r_alu_opcode;
  assign ex_func       = r_func;
  assign ex_rs         = r_rs;
  assign ex_rt         = r_rt;
  assign ex_wreg       = r_wreg;
  assign ex_imm        = r_imm;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_mem_to_reg = r_mem_to_reg;
  assign ex_alu_src    = r_alu_src;
  assign ex_branch     = r_branch;
  assign ex_jump       = r_jump;
  assign ex_jr         = r_jr;
  assign illegal_flag  = r_illegal;

endmodule

// File: tb/tb_id_ex_control_stage.sv
// Directed bench for id_ex_control_stage with hand-computed expectations.
module tb_id_ex_control_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        ex_hold;
  logic        ex_flush;
  logic        id_stall;
  logic        ex_valid;
  logic [3:0]  ex_alu_opcode;
  logic [5:0]  ex_func;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_wreg;
  logic [31:0] ex_imm;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic        ex_alu_src;
  logic        ex_branch;
  logic        ex_jump;
  logic        ex_jr;
  logic        illegal_flag;

  int unsigned n_pass;
  int unsigned n_total;

  id_ex_control_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .ex_hold(ex_hold), .ex_flush(ex_flush), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_alu_opcode(ex_alu_opcode), .ex_func(ex_func),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg), .ex_imm(ex_imm),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_jr(ex_jr), .illegal_flag(illegal_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; id_valid = 1'b0; id_instr = '0; ex_hold = 1'b0; ex_flush = 1'b0;
    step(); step();
    check("rst_valid", ex_valid, 0);
    check("rst_illegal", illegal_flag, 0);
    check("rst_imm", ex_imm, 0);
    check("rst_regwr", ex_reg_write, 0);
    rst_n = 1'b1;

    // addu $3,$1,$2
    id_valid = 1'b1; id_instr = 32'h0022_1821;
    step();
    check("addu_valid", ex_valid, 1);
    check("addu_op", ex_alu_opcode, 4'b0000);
    check("addu_func", ex_func, 6'b100001);
    check("addu_wreg", ex_wreg, 3);
    check("addu_rs", ex_rs, 1);
    check("addu_rt", ex_rt, 2);
    check("addu_regwr", ex_reg_write, 1);
    check("addu_alusrc", ex_alu_src, 0);

    id_instr = 32'h3404_FFFF; // ori $4,$0,0xffff
    step();
    check("ori_imm", ex_imm, 32'h0000_FFFF);
    check("ori_op", ex_alu_opcode, 4'b0100);
    check("ori_wreg", ex_wreg, 4);
    check("ori_alusrc", ex_alu_src, 1);
    id_instr = 32'h3C05_1234; // lui $5,0x1234
    step();
    check("lui_imm", ex_imm, 32'h0000_1234);
    check("lui_op", ex_alu_opcode, 4'b0011);
    id_instr = 32'h2426_FFFF; // addiu $6,$1,-1
    step();
    check("addiu_imm", ex_imm, 32'hFFFF_FFFF);
    check("addiu_op", ex_alu_opcode, 4'b0001);
    check("addiu_wreg", ex_wreg, 6);

    id_instr = 32'h03E0_0008; // jr $31
    step();
    check("jr_jr", ex_jr, 1);
    check("jr_regwr", ex_reg_write, 0);
    check("jr_valid", ex_valid, 1);
    id_instr = 32'h0800_0010; // j
    step();
    check("j_jump", ex_jump, 1);
    check("j_op", ex_alu_opcode, 4'b0001);
    id_instr = 32'h1022_0003; // beq $1,$2
    step();
    check("beq_branch", ex_branch, 1);
    check("beq_op", ex_alu_opcode, 4'b0010);
    check("beq_imm", ex_imm, 32'h0000_0003);
    id_instr = 32'hAC22_0004; // sw $2,4($1)
    step();
    check("sw_memwr", ex_mem_write, 1);
    check("sw_regwr", ex_reg_write, 0);

    // Load-use on rt via addiu destination: not a use, no stall
    id_instr = 32'h8C22_0000; // lw $2,0($1)
    step();
    check("lw_memrd", ex_mem_read, 1);
    check("lw_memtoreg", ex_mem_to_reg, 1);
    check("lw_wreg", ex_wreg, 2);
    id_instr = 32'h24A2_0001; // addiu $2,$5,1
    #1;
    check("nouse_stall", id_stall, 0);
    id_instr = 32'h0042_1821; // addu $3,$2,$2
    #1;
    check("lu_stall", id_stall, 1);
    step();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_regwr", ex_reg_write, 0);
    check("lu_stall_drop", id_stall, 0);
    step();
    check("lu_after_valid", ex_valid, 1);
    check("lu_after_wreg", ex_wreg, 3);
    check("lu_after_func", ex_func, 6'b100001);

    // Illegal opcode, sticky flag
    id_instr = 32'hFC00_0000;
    step();
    check("ill_valid", ex_valid, 0);
    check("ill_flag", illegal_flag, 1);
    id_instr = 32'h0022_1821;
    for (int i = 0; i < 10; i++) step();
    check("ill_held", illegal_flag, 1);
    check("ill_legal_valid", ex_valid, 1);
    @(negedge clk); rst_n = 1'b0; #1;
    check("ill_rst", illegal_flag, 0);
    rst_n = 1'b1;

    // Illegal word with id_valid=0 is ignored
    id_valid = 1'b0; id_instr = 32'hFC00_0000;
    step();
    check("ill_invalid_flag", illegal_flag, 0);
    // Illegal R-type func (add 100000)
    id_valid = 1'b1; id_instr = 32'h0022_1820;
    step();
    check("ill_func_valid", ex_valid, 0);
    check("ill_func_flag", illegal_flag, 1);

    // Hold beats flush
    id_instr = 32'h8C22_0000;
    step();
    ex_hold = 1'b1; ex_flush = 1'b1; id_instr = 32'h0022_1821;
    step(); step(); step();
    check("hold_valid", ex_valid, 1);
    check("hold_memrd", ex_mem_read, 1);
    check("hold_wreg", ex_wreg, 2);
    check("hold_func", ex_func, 6'b000000);
    ex_hold = 1'b0;
    step();
    check("flush_valid", ex_valid, 0);
    check("flush_memrd", ex_mem_read, 0);
    ex_flush = 1'b0;

    // Asynchronous reset mid-cycle
    step();
    check("pre_arst_valid", ex_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", ex_valid, 0);
    check("arst_regwr", ex_reg_write, 0);
    check("arst_wreg", ex_wreg, 0);
    check("arst_func", ex_func, 0);
    check("arst_illegal", illegal_flag, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_ex_control_stage.md
Name: id_ex_control_stage

Overview:
Decode-side producer of the alu_opcode/func interface that the EX-stage ALU control decoder consumes. Decodes the IF/ID instruction into main control signals, the 4-bit alu_opcode and the raw func field. It registers them into the ID/EX pipeline register and detects load-use hazards. Sits between the IF/ID register and the EX stage of the 5-stage pipeline.

Parameters:
DATA_W, 32, instruction/immediate width
REG_AW, 5, register index width

Ports:
clk  in  1  pipeline clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  IF/ID holds a real instruction
id_instr  in  32  instruction word from IF/ID
ex_hold  in  1  downstream stall; EX register keeps its contents
ex_flush  in  1  branch/jump redirect; kill instruction entering EX
id_stall  out  1  combinational load-use stall request to PC and IF/ID
ex_valid  out  1  EX register holds a real instruction
ex_alu_opcode  out  4  0001 add, 0010 sub, 0100 or, 0011 lui, 0000 R-type (use func)
ex_func  out  6  instr[5:0], passed to ALU control
ex_rs  out  5  source register index
ex_rt  out  5  second source register index
ex_wreg  out  5  resolved destination register (rd for R-type, rt otherwise)
ex_imm  out  32  extended immediate
ex_reg_write  out  1  writes the register file
ex_mem_read  out  1  load
ex_mem_write  out  1  store
ex_mem_to_reg  out  1  writeback selects memory data
ex_alu_src  out  1  ALU B operand is ex_imm
ex_branch  out  1  beq
ex_jump  out  1  j
ex_jr  out  1  R-type func 001000
illegal_flag  out  1  sticky illegal-instruction indicator

Behaviour:
- Reset (rst_n=0, asynchronous): every output register is 0 and illegal_flag is 0. Reset during a hold or flush wins immediately.
- Decode table (opcode -> alu_opcode, controls):
  - 000000 R-type -> 0000. func 100001 addu and 100011 subu: reg_write=1, wreg=rd. func 001000 jr: jr=1, reg_write=0.
  - 001001 addiu -> 0001, alu_src, reg_write, sign-extended imm.
  - 001101 ori -> 0100, alu_src, reg_write, zero-extended imm.
  - 001111 lui -> 0011, alu_src, reg_write, zero-extended imm. The ALU performs the shift.
  - 100011 lw -> 0001, alu_src, mem_read, mem_to_reg, reg_write, sign-extended imm.
  - 101011 sw -> 0001, alu_src, mem_write, sign-extended imm.
  - 000100 beq -> 0010, branch, sign-extended imm.
  - 000010 j -> jump. alu_opcode 0001, but the result is unused.
- A write to register 0 is legal: reg_write is still set, and the regfile ignores index 0.
- Illegal: any other opcode, or an R-type func outside {100001, 100011, 001000}. The instruction enters EX as a bubble (ex_valid=0, all controls 0). illegal_flag sets on the next edge and holds until reset. Illegal words with id_valid=0 are ignored.
- Load-use hazard: id_stall = id_valid & ex_valid & ex_mem_read & (ex_wreg != 0) & ((id rs == ex_wreg) | (id uses rt & id rt == ex_wreg)).
  - rt counts as used by R-type, sw and beq.
- Edge update priority (highest first):
  1. reset
  2. ex_hold=1: EX register unchanged, even if ex_flush=1
  3. ex_flush=1: load bubble
  4. id_stall=1: load bubble
  5. otherwise load the decode of id_instr, with ex_valid=id_valid
- A bubble means every control bit and ex_valid are 0. Index and immediate fields may update, but they don't matter.
- Latency: one cycle from the IF/ID word to the EX outputs.
- The stalled instruction re-presents unchanged. After the bubble, id_stall drops because ex_mem_read=0.
- id_stall is independent of ex_hold. The upstream stages freeze whenever either is high.

Test Plan:
- Reset release, id_instr=0x00221821 (addu $3,$1,$2) valid -> after 1 edge: ex_valid=1, alu_opcode=0000, func=100001, wreg=3, reg_write=1, alu_src=0.
- 0x3404FFFF (ori) then 0x3C051234 (lui) -> ex_imm=0x0000FFFF with alu_opcode=0100, then ex_imm=0x00001234 with alu_opcode=0011. 0x2426FFFF (addiu) -> ex_imm=0xFFFFFFFF, alu_opcode=0001.
- 0x8C220000 (lw $2) then 0x00421821 (uses $2) -> id_stall=1 for exactly one cycle, EX gets one bubble, then the addu loads with ex_valid=1.
- 0xFC000000 with id_valid=1 -> ex_valid=0 next edge, illegal_flag=1 and held through 10 legal instructions until rst_n pulse.
- ex_hold=1 together with ex_flush=1 for 3 cycles while EX holds lw -> EX outputs unchanged. The following cycle with flush only -> bubble.
- Assert rst_n=0 mid-cycle while ex_valid=1 -> all outputs 0 before the next clock edge.
